led_rx: RTL and testbench



---
 rtl/led_rx.sv | 134 +++++++++++++
 tb/tb_led_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_rx.sv
// Single-wire LED-strip receiver: decodes pulse widths into bits, frames them on the
// long-low latch gap and publishes the whole frame on a valid latch.
module led_rx #(
    parameter int  CLK_SPEED     = 25_000_000,
    parameter int  LED_CNT       = 3,
    parameter int  CHANNELS      = 3,
    parameter int  BITPERCHANNEL = 8,
    parameter real THRESHOLD     = 0.0000006,
    parameter real HIGH_MAX      = 0.000002,
    parameter real RESET_DETECT  = 0.00004,
    localparam int DATAWIDTH     = LED_CNT * CHANNELS * BITPERCHANNEL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 frame_valid,
    output logic                 frame_error,
    output logic                 busy
);

    // Tiny bias so products like 25e6*6e-7 do not floor to 14 through rounding error.
    localparam real EPS      = 1.0e-6;
    localparam int  TH_CNT   = $rtoi(real'(CLK_SPEED) * THRESHOLD + EPS);
    localparam int  HMAX_CNT = $rtoi(real'(CLK_SPEED) * HIGH_MAX + EPS);
    localparam int  RST_CNT  = $rtoi(real'(CLK_SPEED) * RESET_DETECT + EPS);
    localparam int  CW       = $clog2(RST_CNT + 1);
    localparam int  BW       = $clog2(DATAWIDTH + 2);

    localparam logic [CW-1:0] TH_C   = CW'(TH_CNT);
    localparam logic [CW-1:0] HMAX_C = CW'(HMAX_CNT);
    localparam logic [CW-1:0] RST_C  = CW'(RST_CNT);
    localparam logic [CW-1:0] RST_M1 = CW'(RST_CNT - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] MAX_C  = {CW{1'b1}};
    localparam logic [BW-1:0] DW_B   = BW'(DATAWIDTH);

    typedef enum logic [1:0] {SYNC, READY, HIGH, LOW} state_t;

    state_t                 state;
    logic                   s_meta, s, s_d;
    logic [CW-1:0]          scnt, hcnt, lcnt;
    logic [BW-1:0]          bitcnt;
    logic [DATAWIDTH-1:0]   shadow;
    logic                   rise, fall;

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;
    assign busy = (state == HIGH) || (state == LOW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_meta      <= 1'b0;
            s           <= 1'b0;
            s_d         <= 1'b0;
            state       <= SYNC;
            scnt        <= '0;
            hcnt        <= '0;
            lcnt        <= '0;
            bitcnt      <= '0;
            shadow      <= '0;
            data_o      <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            s_meta      <= din;
            s           <= s_meta;
            s_d         <= s;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;

            case (state)
                // Wait for a full latch gap so a frame joined mid-stream is never decoded.
                SYNC: begin
                    if (s) begin
                        scnt <= '0;
                    end else if (scnt >= RST_M1) begin
                        scnt  <= '0;
                        state <= READY;
                    end else begin
                        scnt <= scnt + ONE_C;
                    end
                end

                READY: begin
                    if (rise) begin
                        state  <= HIGH;
                        hcnt   <= ONE_C;
                        bitcnt <= '0;
                    end
                end

                // Timeout outranks the fall so a pulse longer than the limit is never a bit.
                HIGH: begin
                    if (hcnt > HMAX_C) begin
                        frame_error <= 1'b1;
                        bitcnt      <= '0;
                        scnt        <= '0;
                        state       <= SYNC;
                    end else if (fall) begin
                        if (bitcnt < DW_B)
                            shadow[bitcnt] <= (hcnt > TH_C);
                        if (bitcnt <= DW_B)
                            bitcnt <= bitcnt + 1'b1;
                        lcnt  <= ONE_C;
                        state <= LOW;
                    end else if (hcnt != MAX_C) begin
                        hcnt <= hcnt + ONE_C;
                    end
                end

                LOW: begin
                    if (rise) begin
                        hcnt  <= ONE_C;
                        state <= HIGH;
                    end else if (lcnt == RST_C) begin
                        if (bitcnt == DW_B) begin
                            data_o      <= shadow;
                            frame_valid <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        state <= READY;
                    end else begin
                        lcnt <= lcnt + ONE_C;
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_led_rx.sv
// Directed bench for led_rx: pulse-width bit streams with hand-computed frames.
module tb_led_rx;
    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din = 1'b0;
    logic [DW-1:0] data_o;
    logic          frame_valid, frame_error, busy;

    int   errors = 0;
    int   checks = 0;
    int   vld_cnt = 0;
    int   err_cnt = 0;
    logic busy_at_valid = 1'b1;

    always #5 clk = ~clk;

    led_rx dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .data_o      (data_o),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    // Pulse counters; a pulse lasting two cycles counts twice and trips the delta checks.
    always @(negedge clk) begin
        if (frame_valid) begin
            vld_cnt = vld_cnt + 1;
            busy_at_valid = busy;
        end
        if (frame_error) err_cnt = err_cnt + 1;
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            if (d[i]) begin hold(1'b1, 20); hold(1'b0, 11); end
            else      begin hold(1'b1, 10); hold(1'b0, 21); end
        end
    endtask

    task automatic test_reset;
        hold(1'b0, 3);
        checks++;
        if ({data_o, frame_valid, frame_error, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h fv=%b fe=%b busy=%b, want all 0",
                     data_o, frame_valid, frame_error, busy);
        end
        reset = 1'b0;
        hold(1'b0, 1100);
        checks++;
        if (vld_cnt !== 0 || err_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got vld=%0d err=%0d busy=%b, want 0 0 0", vld_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_default;
        logic [DW-1:0] exp_d;
        int v0, e0;
        exp_d = {9{8'hA5}};
        v0 = vld_cnt; e0 = err_cnt;
        send_frame({1'b0, exp_d}, DW);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL default_busy_in_gap: got %b want 1", busy);
        end
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL default_pulses: got vld=%0d err=%0d want 1 0", vld_cnt - v0, err_cnt - e0);
        end
        checks++;
        if (data_o !== exp_d) begin
            errors++;
            $display("FAIL default_data: got %h want %h", data_o, exp_d);
        end
        checks++;
        if (busy_at_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL default_busy_fall: got at_valid=%b now=%b want 0 0", busy_at_valid, busy);
        end
    endtask

    task automatic test_threshold;
        logic [DW-1:0] exp_d;
        int v0;
        exp_d = {36{2'b10}};
        v0 = vld_cnt;
        for (int i = 0; i < DW; i++) begin
            hold(1'b1, (i % 2 == 1) ? 16 : 15);
            hold(1'b0, 16);
        end
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 1 || data_o !== exp_d) begin
            errors++;
            $display("FAIL threshold_mixed: got vld=%0d data=%h want 1 %h", vld_cnt - v0, data_o, exp_d);
        end
        v0 = vld_cnt;
        for (int i = 0; i < DW; i++) begin
            hold(1'b1, 15);
            hold(1'b0, 16);
        end
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 1 || data_o !== '0) begin
            errors++;
            $display("FAIL threshold_all15: got vld=%0d data=%h want 1 0", vld_cnt - v0, data_o);
        end
    endtask

    task automatic test_loopback;
        logic [DW-1:0] exp_d;
        int v0, e0;
        exp_d = 72'h0123456789ABCDEF01;
        for (int f = 0; f < 2; f++) begin
            v0 = vld_cnt; e0 = err_cnt;
            send_frame({1'b0, exp_d}, DW);
            hold(1'b0, 1250);
            checks++;
            if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0 || data_o !== exp_d) begin
                errors++;
                $display("FAIL loopback_frame%0d: got vld=%0d err=%0d data=%h want 1 0 %h",
                         f, vld_cnt - v0, err_cnt - e0, data_o, exp_d);
            end
        end
    endtask

    task automatic test_bad_length;
        logic [DW-1:0] keep;
        int v0, e0;
        keep = data_o;
        v0 = vld_cnt; e0 = err_cnt;
        send_frame({1'b1, 72'hFFEEDDCCBBAA998877}, DW - 1);
        hold(1'b0, 1250);
        checks++;
        if (err_cnt - e0 !== 1 || vld_cnt - v0 !== 0 || data_o !== keep) begin
            errors++;
            $display("FAIL short_frame: got err=%0d vld=%0d data=%h want 1 0 %h",
                     err_cnt - e0, vld_cnt - v0, data_o, keep);
        end
        v0 = vld_cnt; e0 = err_cnt;
        send_frame({1'b1, 72'h112233445566778899}, DW + 1);
        hold(1'b0, 1250);
        checks++;
        if (err_cnt - e0 !== 1 || vld_cnt - v0 !== 0 || data_o !== keep) begin
            errors++;
            $display("FAIL long_frame: got err=%0d vld=%0d data=%h want 1 0 %h",
                     err_cnt - e0, vld_cnt - v0, data_o, keep);
        end
    endtask

    task automatic test_stuck_high;
        logic [DW-1:0] keep, exp_d;
        int v0, e0;
        keep = data_o;
        exp_d = 72'h5A5A5A5A5A5A5A5A5A;
        e0 = err_cnt; v0 = vld_cnt;
        hold(1'b1, 51);
        hold(1'b0, 20);
        checks++;
        if (err_cnt - e0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stuck_timeout: got err=%0d busy=%b want 1 0", err_cnt - e0, busy);
        end
        e0 = err_cnt;
        send_frame({1'b0, exp_d}, DW);
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 0 || data_o !== keep) begin
            errors++;
            $display("FAIL stuck_ungapped: got vld=%0d err=%0d data=%h want 0 0 %h",
                     vld_cnt - v0, err_cnt - e0, data_o, keep);
        end
        send_frame({1'b0, exp_d}, DW);
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 1 || data_o !== exp_d) begin
            errors++;
            $display("FAIL stuck_recover: got vld=%0d data=%h want 1 %h", vld_cnt - v0, data_o, exp_d);
        end
    endtask

    task automatic test_reset_midframe;
        logic [DW-1:0] exp_d;
        int v0, e0;
        exp_d = 72'hC3C3C3C3C3C3C3C3C3;
        send_frame({1'b0, exp_d}, 30);
        din = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({data_o, frame_valid, frame_error, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset: got data=%h fv=%b fe=%b busy=%b want all 0",
                     data_o, frame_valid, frame_error, busy);
        end
        hold(1'b0, 3);
        reset = 1'b0;
        v0 = vld_cnt; e0 = err_cnt;
        send_frame({1'b0, exp_d}, DW);
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 0 || err_cnt - e0 !== 0 || data_o !== '0) begin
            errors++;
            $display("FAIL reset_ungapped: got vld=%0d err=%0d data=%h want 0 0 0",
                     vld_cnt - v0, err_cnt - e0, data_o);
        end
        send_frame({1'b0, exp_d}, DW);
        hold(1'b0, 1250);
        checks++;
        if (vld_cnt - v0 !== 1 || err_cnt - e0 !== 0 || data_o !== exp_d) begin
            errors++;
            $display("FAIL reset_recover: got vld=%0d err=%0d data=%h want 1 0 %h",
                     vld_cnt - v0, err_cnt - e0, data_o, exp_d);
        end
    endtask

    initial begin
        test_reset;
        test_default;
        test_threshold;
        test_loopback;
        test_bad_length;
        test_stuck_high;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
